// File: rtl/sccb_slave_emu_if.sv
// SCCB pin bundle: oversampled SIO_C/SIO_D samples in, open-drain SDA pull-down out.
interface sccb_slave_emu_if;
  logic sio_c_in;
  logic sio_d_in;
  logic sio_d_oe;

  modport master (output sio_c_in, output sio_d_in, input sio_d_oe);
  modport slave  (input sio_c_in, input sio_d_in, output sio_d_oe);
endinterface

// File: rtl/sccb_slave_emu.sv
// SCCB responder emulating the OV7660 register port: START/STOP detection on
// oversampled pins, 3-phase write / 2-phase write + 2-phase read decoding, and
// a 256-entry register file behind a persistent sub-address pointer.
module sccb_slave_emu #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter bit         ACK_EN = 1'b1,
  parameter logic [7:0] PID_H  = 8'h76,
  parameter logic [7:0] PID_L  = 8'h60
) (
  input  logic            fclk,
  input  logic            rst_n,
  sccb_slave_emu_if.slave sccb,
  output logic            reg_wr_valid,
  output logic [7:0]      reg_wr_addr,
  output logic [7:0]      reg_wr_data,
  output logic            busy,
  output logic [15:0]     id_miss_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_SUB_X, S_SUB, S_SUB2_X, S_WDATA,
    S_WD_X, S_RD_X, S_RDATA, S_RD_NA, S_IGNORE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  c_sync, d_sync;
  logic        c_prev, d_prev;
  logic        scl, sda;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  tx, tx_n;
  logic [3:0]  txcnt, txcnt_n;
  logic        oe_q, oe_n;
  logic        ack_ph, ack_ph_n;
  logic [7:0]  ptr, ptr_n;
  logic        wr_en, miss_inc, wr_pend;
  logic [7:0]  byte_in;
  logic [7:0]  rd_val;
  logic [7:0]  regs [256];

  assign scl       = c_sync[1];
  assign sda       = d_sync[1];
  assign scl_rise  = scl & ~c_prev;
  assign scl_fall  = ~scl & c_prev;
  // SCL must be high in both samples so bus conditions never coincide with SCL edges
  assign start_det = scl & c_prev & d_prev & ~sda;
  assign stop_det  = scl & c_prev & ~d_prev & sda;
  assign byte_in   = {shreg[6:0], sda};
  assign rd_val    = regs[ptr];
  assign sccb.sio_d_oe = oe_q;

  // Two-stage pin synchronisers plus one-cycle delayed copies for edge detection
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
      d_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], sccb.sio_c_in};
      d_sync <= {d_sync[0], sccb.sio_d_in};
      c_prev <= c_sync[1];
      d_prev <= d_sync[1];
    end
  end

  // FSM state register
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and datapath decode; bus conditions override bit activity
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    tx_n     = tx;
    txcnt_n  = txcnt;
    oe_n     = oe_q;
    ack_ph_n = ack_ph;
    ptr_n    = ptr;
    wr_en    = 1'b0;
    miss_inc = 1'b0;
    if (stop_det) begin
      state_n  = S_IDLE;
      oe_n     = 1'b0;
      bitcnt_n = '0;
      ack_ph_n = 1'b0;
    end else if (start_det) begin
      state_n  = S_ADDR;
      bitcnt_n = '0;
      ack_ph_n = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise) begin
          shreg_n  = byte_in;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (byte_in[7:1] != DEV_ID) begin
              state_n  = S_IGNORE;
              miss_inc = 1'b1;
            end else if (byte_in[0]) begin
              state_n = S_RD_X;
            end else begin
              state_n = S_SUB_X;
            end
          end
        end
        S_SUB: if (scl_rise) begin
          shreg_n  = byte_in;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            ptr_n   = byte_in;
            state_n = S_SUB2_X;
          end
        end
        S_WDATA: if (scl_rise) begin
          shreg_n  = byte_in;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            wr_en   = 1'b1;
            state_n = S_WD_X;
          end
        end
        // 9th bit: the first SCL fall opens the ack low phase, the second closes it.
        // A STOP after SUB2_X ends the transaction as a 2-phase write; the pointer
        // is already latched, so entering WDATA early is harmless.
        S_SUB_X, S_SUB2_X, S_WD_X, S_RD_X: if (scl_fall) begin
          if (!ack_ph) begin
            oe_n     = ACK_EN;
            ack_ph_n = 1'b1;
          end else begin
            ack_ph_n = 1'b0;
            oe_n     = 1'b0;
            if (state == S_RD_X) begin
              oe_n    = ~rd_val[7];
              tx_n    = {rd_val[6:0], 1'b0};
              txcnt_n = 4'd1;
              state_n = S_RDATA;
            end else if (state == S_SUB_X) begin
              state_n = S_SUB;
            end else if (state == S_SUB2_X) begin
              state_n = S_WDATA;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_RDATA: if (scl_fall) begin
          if (txcnt == 4'd8) begin
            oe_n    = 1'b0;
            state_n = S_RD_NA;
          end else begin
            oe_n    = ~tx[7];
            tx_n    = {tx[6:0], 1'b0};
            txcnt_n = txcnt + 4'd1;
          end
        end
        S_RD_NA: if (scl_rise) state_n = S_IGNORE;
        S_IGNORE: oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  // Datapath registers, register file, write-commit pulse and miss counter
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt       <= '0;
      shreg        <= '0;
      tx           <= '0;
      txcnt        <= '0;
      oe_q         <= 1'b0;
      ack_ph       <= 1'b0;
      ptr          <= '0;
      wr_pend      <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      busy         <= 1'b0;
      id_miss_cnt  <= '0;
      for (int unsigned i = 0; i < 256; i++) regs[i[7:0]] <= 8'h00;
      regs[8'h0A] <= PID_H;
      regs[8'h0B] <= PID_L;
    end else begin
      bitcnt       <= bitcnt_n;
      shreg        <= shreg_n;
      tx           <= tx_n;
      txcnt        <= txcnt_n;
      oe_q         <= oe_n;
      ack_ph       <= ack_ph_n;
      ptr          <= ptr_n;
      wr_pend      <= wr_en;
      reg_wr_valid <= wr_pend;
      busy         <= (state_n != S_IDLE);
      if (wr_en) begin
        regs[ptr]   <= byte_in;
        reg_wr_addr <= ptr;
        reg_wr_data <= byte_in;
      end
      if (miss_inc && (id_miss_cnt != '1)) id_miss_cnt <= id_miss_cnt + 16'd1;
    end
  end

endmodule
